// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer with registered lookup and flash-clear FSM.
// Optional macro BTB_PLRU_EN: per-set tree pseudo-LRU replacement; otherwise a global
// round-robin victim counter is used.
module btb_set_assoc #(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned TAG_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic [31:0] pc,
  input  logic        update,
  input  logic [31:0] updatePc,
  input  logic [31:0] destIn,
  input  logic        unconditionalIn,
  output logic [31:0] destOut,
  output logic        validOut,
  output logic        unconditionalOut,
  output logic        busyOut
);

  localparam int unsigned SETS     = ENTRIES / WAYS;
  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_LSB  = IDX_BITS + 2;
  localparam bit          HAS_REPL = (WAYS > 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e               r_state, w_state_d;
  logic [IDX_BITS-1:0]  r_clr_cnt, w_clr_cnt_d;

  logic [WAYS-1:0]      r_valid  [SETS];
  logic [WAYS-1:0]      r_uncond [SETS];
  logic [TAG_BITS-1:0]  r_tag    [SETS][WAYS];
  logic [31:0]          r_dest   [SETS][WAYS];

  logic [31:0]          r_dest_out;
  logic                 r_valid_out, r_uncond_out;

  logic [IDX_BITS-1:0]  w_lk_idx, w_up_idx;
  logic [TAG_BITS-1:0]  w_lk_tag, w_up_tag;
  logic                 w_lk_hit, w_up_hit, w_up_free, w_wr_en, w_wr_evict;
  logic [WAY_BITS-1:0]  w_lk_way, w_up_hit_way, w_up_free_way, w_victim, w_wr_way;
  logic                 w_unused;

  assign w_lk_idx = pc[IDX_BITS+1:2];
  assign w_lk_tag = pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
  assign w_up_idx = updatePc[IDX_BITS+1:2];
  assign w_up_tag = updatePc[TAG_LSB+TAG_BITS-1:TAG_LSB];
  assign w_unused = ^{pc, updatePc};

`ifdef BTB_PLRU_EN
  localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int unsigned PIDX_W = (PLRU_W > 1) ? $clog2(PLRU_W) : 1;

  logic [PLRU_W-1:0] r_plru [SETS];
  logic [PLRU_W-1:0] w_plru_lk, w_plru_up_base, w_plru_up;

  // Walk the tree from the root; each node bit selects the subtree holding the victim.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_W-1:0] t);
    int unsigned node;
    node = 1;
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      node = 2 * node + {31'b0, t[PIDX_W'(node - 1)]};
    end
    return WAY_BITS'(node - WAYS);
  endfunction

  // Point every node on the path to way w at the other subtree.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                   input logic [WAY_BITS-1:0] w);
    logic [PLRU_W-1:0] r;
    int unsigned       node;
    r    = t;
    node = 1;
    for (int l = int'(WAY_BITS) - 1; l >= 0; l--) begin
      r[PIDX_W'(node - 1)] = ~w[l];
      node = 2 * node + {31'b0, w[l]};
    end
    return r;
  endfunction

  // Lookup touch first, then the write touch chained on top when both hit the same set.
  always_comb begin
    w_plru_lk      = plru_touch(r_plru[w_lk_idx], w_lk_way);
    w_plru_up_base = (w_lk_hit && (w_lk_idx == w_up_idx)) ? w_plru_lk : r_plru[w_up_idx];
    w_plru_up      = plru_touch(w_plru_up_base, w_wr_way);
    w_victim       = HAS_REPL ? plru_victim(r_plru[w_up_idx]) : '0;
  end
`else
  logic [WAY_BITS-1:0] r_rr;

  // Global round-robin pointer selects the victim.
  always_comb begin
    w_victim = HAS_REPL ? r_rr : '0;
  end
`endif

  // Lookup hit detection against the current array contents (read-before-write).
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_way = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (r_valid[w_lk_idx][i] && (r_tag[w_lk_idx][i] == w_lk_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_way = WAY_BITS'(i);
      end
    end
  end

  // Update way selection: in-place hit, else lowest invalid way, else victim.
  always_comb begin
    w_up_hit      = 1'b0;
    w_up_hit_way  = '0;
    w_up_free     = 1'b0;
    w_up_free_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (r_valid[w_up_idx][i] && (r_tag[w_up_idx][i] == w_up_tag)) begin
        w_up_hit     = 1'b1;
        w_up_hit_way = WAY_BITS'(i);
      end
      if (!r_valid[w_up_idx][i]) begin
        w_up_free     = 1'b1;
        w_up_free_way = WAY_BITS'(i);
      end
    end
    w_wr_en    = update && (r_state == StRun);
    w_wr_evict = w_wr_en && !w_up_hit && !w_up_free;
    w_wr_way   = w_up_hit ? w_up_hit_way : (w_up_free ? w_up_free_way : w_victim);
  end

  // Flash-clear FSM next state: one set per enabled cycle, then run.
  always_comb begin
    w_state_d   = r_state;
    w_clr_cnt_d = r_clr_cnt;
    unique case (r_state)
      StClear: begin
        w_clr_cnt_d = r_clr_cnt + 1'b1;
        if (r_clr_cnt == IDX_BITS'(SETS - 1)) begin
          w_state_d   = StRun;
          w_clr_cnt_d = '0;
        end
      end
      StRun:   w_state_d = StRun;
      default: w_state_d = StClear;
    endcase
  end

  // State, arrays and output registers; everything holds when clkEn is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StClear;
      r_clr_cnt    <= '0;
      r_dest_out   <= '0;
      r_valid_out  <= 1'b0;
      r_uncond_out <= 1'b0;
`ifndef BTB_PLRU_EN
      r_rr         <= '0;
`endif
    end else if (clkEn) begin
      r_state   <= w_state_d;
      r_clr_cnt <= w_clr_cnt_d;
      if (r_state == StClear) begin
        r_valid[r_clr_cnt] <= '0;
`ifdef BTB_PLRU_EN
        r_plru[r_clr_cnt]  <= '0;
`endif
        r_dest_out   <= '0;
        r_valid_out  <= 1'b0;
        r_uncond_out <= 1'b0;
      end else begin
        r_valid_out  <= w_lk_hit;
        r_dest_out   <= w_lk_hit ? r_dest[w_lk_idx][w_lk_way] : '0;
        r_uncond_out <= w_lk_hit & r_uncond[w_lk_idx][w_lk_way];
        if (w_wr_en) begin
          r_valid[w_up_idx][w_wr_way]  <= 1'b1;
          r_uncond[w_up_idx][w_wr_way] <= unconditionalIn;
          r_tag[w_up_idx][w_wr_way]    <= w_up_tag;
          r_dest[w_up_idx][w_wr_way]   <= destIn;
        end
`ifdef BTB_PLRU_EN
        if (HAS_REPL && w_lk_hit) r_plru[w_lk_idx] <= w_plru_lk;
        if (HAS_REPL && w_wr_en)  r_plru[w_up_idx] <= w_plru_up;
`else
        if (HAS_REPL && w_wr_evict) r_rr <= r_rr + 1'b1;
`endif
      end
    end
  end

  assign destOut          = r_dest_out;
  assign validOut         = r_valid_out;
  assign unconditionalOut = r_uncond_out;
  assign busyOut          = (r_state == StClear);

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed self-checking bench for btb_set_assoc (default 64 entries, 2 ways, 12-bit tags).
module tb_btb_set_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b1;
  logic [31:0] pc = '0;
  logic        update = 1'b0;
  logic [31:0] updatePc = '0;
  logic [31:0] destIn = '0;
  logic        unconditionalIn = 1'b0;
  logic [31:0] destOut;
  logic        validOut;
  logic        unconditionalOut;
  logic        busyOut;

  int errors = 0;
  int checks = 0;
  int n;

  // Set 3 entries with three distinct tags (tag field starts at bit 7).
  localparam logic [31:0] PcA = 32'h0000_008C;
  localparam logic [31:0] PcB = 32'h0000_010C;
  localparam logic [31:0] PcC = 32'h0000_018C;

  btb_set_assoc dut (
    .clk              (clk),
    .rst              (rst),
    .clkEn            (clkEn),
    .pc               (pc),
    .update           (update),
    .updatePc         (updatePc),
    .destIn           (destIn),
    .unconditionalIn  (unconditionalIn),
    .destOut          (destOut),
    .validOut         (validOut),
    .unconditionalOut (unconditionalOut),
    .busyOut          (busyOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counts enabled cycles until busyOut drops, bounded so a stuck FSM still ends the run.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busyOut === 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  task automatic lookup(input logic [31:0] a);
    update = 1'b0;
    pc     = a;
    step();
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic u);
    update          = 1'b1;
    updatePc        = a;
    destIn          = d;
    unconditionalIn = u;
    pc              = 32'h0000_0FF0;
    step();
    update          = 1'b0;
  endtask

  initial begin
    // Reset and flash clear; updates during the clear must be dropped.
    rst = 1'b1;
    step();
    chk("rst_busy", {31'b0, busyOut}, 32'd1);
    chk("rst_valid", {31'b0, validOut}, 32'd0);
    chk("rst_dest", destOut, 32'h0);
    chk("rst_uncond", {31'b0, unconditionalOut}, 32'd0);
    rst             = 1'b0;
    update          = 1'b1;
    updatePc        = 32'h0000_1000;
    destIn          = 32'h0000_DEAD;
    unconditionalIn = 1'b1;
    pc              = 32'h0000_1000;
    step();
    step();
    chk("clr_busy", {31'b0, busyOut}, 32'd1);
    chk("clr_lookup_miss", {31'b0, validOut}, 32'd0);
    count_busy(n);
    chk("clr_len", n, 32'd30);
    lookup(32'h0000_1000);
    chk("clr_drop_upd", {31'b0, validOut}, 32'd0);
    chk("run_busy", {31'b0, busyOut}, 32'd0);

    // Basic write then hit; same set with a different tag misses.
    write(32'h0000_1000, 32'h0000_2000, 1'b1);
    lookup(32'h0000_1000);
    chk("hit_valid", {31'b0, validOut}, 32'd1);
    chk("hit_dest", destOut, 32'h0000_2000);
    chk("hit_uncond", {31'b0, unconditionalOut}, 32'd1);
    lookup(32'h0000_1080);
    chk("tagmiss_valid", {31'b0, validOut}, 32'd0);
    chk("tagmiss_dest", destOut, 32'h0);

    // Replacement: fill set 3 with A, B, hit A, then write C.
    write(PcA, 32'h0000_A000, 1'b0);
    write(PcB, 32'h0000_B000, 1'b0);
    lookup(PcA);
    chk("A_hit", destOut, 32'h0000_A000);
    write(PcC, 32'h0000_C000, 1'b0);
    lookup(PcA);
`ifdef BTB_PLRU_EN
    chk("plru_A_kept", {31'b0, validOut}, 32'd1);
`else
    chk("rr_A_evicted", {31'b0, validOut}, 32'd0);
`endif
    lookup(PcB);
`ifdef BTB_PLRU_EN
    chk("plru_B_evicted", {31'b0, validOut}, 32'd0);
`else
    chk("rr_B_kept", destOut, 32'h0000_B000);
`endif
    lookup(PcC);
    chk("C_hit", destOut, 32'h0000_C000);
    chk("C_uncond", {31'b0, unconditionalOut}, 32'd0);

    // In-place overwrite of C must not evict the surviving neighbour.
    write(PcC, 32'h0000_C100, 1'b1);
    lookup(PcC);
    chk("C_inplace_dest", destOut, 32'h0000_C100);
    chk("C_inplace_uncond", {31'b0, unconditionalOut}, 32'd1);
`ifdef BTB_PLRU_EN
    lookup(PcA);
    chk("plru_neighbour", destOut, 32'h0000_A000);
`else
    lookup(PcB);
    chk("rr_neighbour", destOut, 32'h0000_B000);
`endif

    // Same-edge update and lookup return the old contents first.
    update          = 1'b1;
    updatePc        = 32'h0000_1000;
    destIn          = 32'h0000_3000;
    unconditionalIn = 1'b0;
    pc              = 32'h0000_1000;
    step();
    chk("rbw_old_dest", destOut, 32'h0000_2000);
    chk("rbw_old_uncond", {31'b0, unconditionalOut}, 32'd1);
    lookup(32'h0000_1000);
    chk("rbw_new_dest", destOut, 32'h0000_3000);
    chk("rbw_new_uncond", {31'b0, unconditionalOut}, 32'd0);

    // Stall: state, arrays and outputs hold while clkEn is low.
    clkEn    = 1'b0;
    update   = 1'b1;
    updatePc = 32'h0000_1000;
    destIn   = 32'h0000_5555;
    for (int i = 0; i < 5; i++) begin
      pc = PcA + 32'(i * 4);
      step();
      chk("stall_dest", destOut, 32'h0000_3000);
      chk("stall_valid", {31'b0, validOut}, 32'd1);
    end
    clkEn = 1'b1;
    lookup(32'h0000_1000);
    chk("stall_contents", destOut, 32'h0000_3000);

    // Stall mid-clear: the clear counter must not advance.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    clkEn = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("clr_stall_busy", {31'b0, busyOut}, 32'd1);
    clkEn = 1'b1;
    count_busy(n);
    chk("clr_stall_len", n, 32'd22);

    // Reset reasserted at set 10 restarts the full clear.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reclr_busy", {31'b0, busyOut}, 32'd1);
    count_busy(n);
    chk("reclr_len", n, 32'd32);
    lookup(32'h0000_1000);
    chk("reclr_cleared", {31'b0, validOut}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
